pipe_hazard_ctrl: RTL and testbench

Parametrised hazard controller for the five-stage pipelined CPU. It keeps its own shadow scoreboard of the instructions in EX, MEM and WB: valid bit, destination register, and regwrite/memread/flagwrite. From that scoreboard it drives the operand forward selects, load-use stalls, taken-branch flushes and whole-pipeline freezes on data-memory wait. It sits beside the decode stage and adds stall, flush and memory back-pressure on top of plain forwarding. Saturating stall and flush counters support performance measurement.

---
 rtl/pipe_hazard_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard controller for a five-stage pipeline. It sits beside the decode stage
// and keeps a shadow scoreboard of the instructions in EX, MEM and WB. From
// that scoreboard it derives the operand forward selects, load-use stalls,
// taken-branch flushes and whole-pipeline freezes on data-memory wait. Two
// saturating counters record stall and flush cycles.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   dec_valid                  decode holds a real instruction
//   dec_ra/dec_rb              source register addresses
//   dec_use_ra/dec_use_rb      source operand is actually read
//   dec_rd                     destination register
//   dec_regwrite/memread/flagwrite  decode control bits
//   dec_use_flags              decode is a flag-conditional branch
//   br_taken                   branch resolved taken in decode
//   mem_ready                  data memory completes this cycle
//   fwd_a/fwd_b                0 regfile, 1 EX, 2 MEM, 3 WB
//   fwd_flags                  take flags live from the EX ALU
//   stall_fd/bubble_ex         load-use stall and NOP insertion
//   flush_fd                   clear fetch/decode register
//   freeze                     hold every pipeline register
//   ex_valid/mem_valid/wb_valid scoreboard valid bits
//   stall_cnt/flush_cnt        saturating event counters
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int REG_AW    = 5,
   parameter int ZERO_REG  = 31,
   parameter int WB_BYPASS = 1,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              dec_valid,
   input  logic [REG_AW-1:0] dec_ra,
   input  logic [REG_AW-1:0] dec_rb,
   input  logic              dec_use_ra,
   input  logic              dec_use_rb,
   input  logic [REG_AW-1:0] dec_rd,
   input  logic              dec_regwrite,
   input  logic              dec_memread,
   input  logic              dec_flagwrite,
   input  logic              dec_use_flags,
   input  logic              br_taken,
   input  logic              mem_ready,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              fwd_flags,
   output logic              stall_fd,
   output logic              bubble_ex,
   output logic              flush_fd,
   output logic              freeze,
   output logic              ex_valid,
   output logic              mem_valid,
   output logic              wb_valid,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [REG_AW-1:0] ZERO_A  = REG_AW'(ZERO_REG);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;

   // Scoreboard. Only the fields some later decision looks at are kept:
   // flagwrite matters only in EX, memread only in EX and MEM.
   logic              ex_valid_q,  ex_valid_d;
   logic [REG_AW-1:0] ex_rd_q,     ex_rd_d;
   logic              ex_rw_q,     ex_rw_d;
   logic              ex_mr_q,     ex_mr_d;
   logic              ex_fw_q,     ex_fw_d;
   logic              mem_valid_q, mem_valid_d;
   logic [REG_AW-1:0] mem_rd_q,    mem_rd_d;
   logic              mem_rw_q,    mem_rw_d;
   logic              mem_mr_q,    mem_mr_d;
   logic              wb_valid_q,  wb_valid_d;
   logic [REG_AW-1:0] wb_rd_q,     wb_rd_d;
   logic              wb_rw_q,     wb_rw_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic ex_hit_a, mem_hit_a, wb_hit_a;
   logic ex_hit_b, mem_hit_b, wb_hit_b;
   logic load_use, freeze_w, stall_w, flush_w;

   function automatic logic src_hit(input logic              v,
                                    input logic              rw,
                                    input logic [REG_AW-1:0] rd,
                                    input logic [REG_AW-1:0] src,
                                    input logic              use_src);
      return v & rw & use_src & (rd == src) & (src != ZERO_A);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic ex_h,
                                          input logic mem_h,
                                          input logic wb_h);
      if (ex_h)                          return 2'd1;
      else if (mem_h)                    return 2'd2;
      else if ((WB_BYPASS != 0) && wb_h) return 2'd3;
      else                               return 2'd0;
   endfunction

   assign ex_hit_a  = src_hit(ex_valid_q,  ex_rw_q,  ex_rd_q,  dec_ra, dec_use_ra);
   assign mem_hit_a = src_hit(mem_valid_q, mem_rw_q, mem_rd_q, dec_ra, dec_use_ra);
   assign wb_hit_a  = src_hit(wb_valid_q,  wb_rw_q,  wb_rd_q,  dec_ra, dec_use_ra);
   assign ex_hit_b  = src_hit(ex_valid_q,  ex_rw_q,  ex_rd_q,  dec_rb, dec_use_rb);
   assign mem_hit_b = src_hit(mem_valid_q, mem_rw_q, mem_rd_q, dec_rb, dec_use_rb);
   assign wb_hit_b  = src_hit(wb_valid_q,  wb_rw_q,  wb_rd_q,  dec_rb, dec_use_rb);

   // Forward selects stay live during a freeze: the scoreboard is held, so
   // they keep pointing at the same producers.
   assign fwd_a     = fwd_sel(ex_hit_a, mem_hit_a, wb_hit_a);
   assign fwd_b     = fwd_sel(ex_hit_b, mem_hit_b, wb_hit_b);
   assign fwd_flags = dec_use_flags & ex_valid_q & ex_fw_q;

   // A load in MEM that has not completed blocks everything; stall and flush
   // are suppressed so they are re-evaluated once the memory answers.
   assign freeze_w = ~mem_ready & mem_valid_q & mem_mr_q;
   assign load_use = dec_valid & ex_mr_q & (ex_hit_a | ex_hit_b);
   assign stall_w  = load_use & ~freeze_w;
   assign flush_w  = br_taken & dec_valid & ~stall_w & ~freeze_w;

   assign freeze    = freeze_w;
   assign stall_fd  = stall_w;
   assign bubble_ex = stall_w;
   // flush_fd is driven purely by decode inputs; mask it so every output reads
   // 0 while reset is held.
   assign flush_fd  = flush_w & reset;

   assign ex_valid  = ex_valid_q;
   assign mem_valid = mem_valid_q;
   assign wb_valid  = wb_valid_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

   always_comb begin
      ex_valid_d  = ex_valid_q;
      ex_rd_d     = ex_rd_q;
      ex_rw_d     = ex_rw_q;
      ex_mr_d     = ex_mr_q;
      ex_fw_d     = ex_fw_q;
      mem_valid_d = mem_valid_q;
      mem_rd_d    = mem_rd_q;
      mem_rw_d    = mem_rw_q;
      mem_mr_d    = mem_mr_q;
      wb_valid_d  = wb_valid_q;
      wb_rd_d     = wb_rd_q;
      wb_rw_d     = wb_rw_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;

      if (!freeze_w) begin
         wb_valid_d  = mem_valid_q;
         wb_rd_d     = mem_rd_q;
         wb_rw_d     = mem_rw_q;
         mem_valid_d = ex_valid_q;
         mem_rd_d    = ex_rd_q;
         mem_rw_d    = ex_rw_q;
         mem_mr_d    = ex_mr_q;
         // Bubbles and flushed slots enter EX invalid.
         ex_valid_d  = dec_valid & ~stall_w & ~flush_w;
         ex_rd_d     = dec_rd;
         ex_rw_d     = dec_regwrite;
         ex_mr_d     = dec_memread;
         ex_fw_d     = dec_flagwrite;
      end

      if (stall_w && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_w && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_valid_q  <= 1'b0;
         ex_rd_q     <= '0;
         ex_rw_q     <= 1'b0;
         ex_mr_q     <= 1'b0;
         ex_fw_q     <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_rd_q    <= '0;
         mem_rw_q    <= 1'b0;
         mem_mr_q    <= 1'b0;
         wb_valid_q  <= 1'b0;
         wb_rd_q     <= '0;
         wb_rw_q     <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_valid_q  <= ex_valid_d;
         ex_rd_q     <= ex_rd_d;
         ex_rw_q     <= ex_rw_d;
         ex_mr_q     <= ex_mr_d;
         ex_fw_q     <= ex_fw_d;
         mem_valid_q <= mem_valid_d;
         mem_rd_q    <= mem_rd_d;
         mem_rw_q    <= mem_rw_d;
         mem_mr_q    <= mem_mr_d;
         wb_valid_q  <= wb_valid_d;
         wb_rd_q     <= wb_rd_d;
         wb_rw_q     <= wb_rw_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Directed bench for pipe_hazard_ctrl. Two instances share the decode inputs:
// dut with WB forwarding, dut_nb without it. Counters are narrowed to 4 bits
// so saturation is reached quickly.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   localparam int AW = 5;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          dec_valid;
   logic [AW-1:0] dec_ra, dec_rb, dec_rd;
   logic          dec_use_ra, dec_use_rb;
   logic          dec_regwrite, dec_memread, dec_flagwrite, dec_use_flags;
   logic          br_taken, mem_ready;

   logic [1:0]    fwd_a, fwd_b;
   logic          fwd_flags, stall_fd, bubble_ex, flush_fd, freeze;
   logic          ex_valid, mem_valid, wb_valid;
   logic [CW-1:0] stall_cnt, flush_cnt;

   logic [1:0]    nb_fwd_a, nb_fwd_b;
   logic          nb_fwd_flags, nb_stall_fd, nb_bubble_ex, nb_flush_fd, nb_freeze;
   logic          nb_ex_valid, nb_mem_valid, nb_wb_valid;
   logic [CW-1:0] nb_stall_cnt, nb_flush_cnt;

   int nvec = 0;
   int nerr = 0;
   int exp_stall = 0;
   int exp_flush = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.REG_AW(AW), .ZERO_REG(31), .WB_BYPASS(1), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .dec_valid(dec_valid),
      .dec_ra(dec_ra), .dec_rb(dec_rb), .dec_use_ra(dec_use_ra), .dec_use_rb(dec_use_rb),
      .dec_rd(dec_rd), .dec_regwrite(dec_regwrite), .dec_memread(dec_memread),
      .dec_flagwrite(dec_flagwrite), .dec_use_flags(dec_use_flags),
      .br_taken(br_taken), .mem_ready(mem_ready),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_flags(fwd_flags), .stall_fd(stall_fd),
      .bubble_ex(bubble_ex), .flush_fd(flush_fd), .freeze(freeze),
      .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

   pipe_hazard_ctrl #(.REG_AW(AW), .ZERO_REG(31), .WB_BYPASS(0), .CNT_W(CW)) dut_nb (
      .clk(clk), .reset(reset), .dec_valid(dec_valid),
      .dec_ra(dec_ra), .dec_rb(dec_rb), .dec_use_ra(dec_use_ra), .dec_use_rb(dec_use_rb),
      .dec_rd(dec_rd), .dec_regwrite(dec_regwrite), .dec_memread(dec_memread),
      .dec_flagwrite(dec_flagwrite), .dec_use_flags(dec_use_flags),
      .br_taken(br_taken), .mem_ready(mem_ready),
      .fwd_a(nb_fwd_a), .fwd_b(nb_fwd_b), .fwd_flags(nb_fwd_flags), .stall_fd(nb_stall_fd),
      .bubble_ex(nb_bubble_ex), .flush_fd(nb_flush_fd), .freeze(nb_freeze),
      .ex_valid(nb_ex_valid), .mem_valid(nb_mem_valid), .wb_valid(nb_wb_valid),
      .stall_cnt(nb_stall_cnt), .flush_cnt(nb_flush_cnt));

   // Stimulus helpers: advance one clock, and load a decode slot.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_dec(input logic v, input int ra, input logic use_ra,
                          input int rb, input logic use_rb, input int rd,
                          input logic rw, input logic mr, input logic fw,
                          input logic use_fl, input logic br);
      dec_valid     = v;
      dec_ra        = AW'(ra);
      dec_use_ra    = use_ra;
      dec_rb        = AW'(rb);
      dec_use_rb    = use_rb;
      dec_rd        = AW'(rd);
      dec_regwrite  = rw;
      dec_memread   = mr;
      dec_flagwrite = fw;
      dec_use_flags = use_fl;
      br_taken      = br;
   endtask

   task automatic idle();
      set_dec(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      idle();
      repeat (3) step();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      mem_ready = 1'b1;
      set_dec(1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      #3;
      nvec++; if ({fwd_a, fwd_b, fwd_flags} !== 5'd0) begin nerr++; $display("FAIL reset_fwd got=%b exp=0", {fwd_a, fwd_b, fwd_flags}); end
      nvec++; if ({stall_fd, bubble_ex, flush_fd, freeze} !== 4'd0) begin nerr++; $display("FAIL reset_ctrl got=%b exp=0000", {stall_fd, bubble_ex, flush_fd, freeze}); end
      nvec++; if ({ex_valid, mem_valid, wb_valid} !== 3'd0) begin nerr++; $display("FAIL reset_valid got=%b exp=000", {ex_valid, mem_valid, wb_valid}); end
      nvec++; if (stall_cnt !== 0 || flush_cnt !== 0) begin nerr++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
      idle();
      step();
      reset = 1'b1;
      step();
      $display("test_reset done");
   endtask

   task automatic test_forward();
      set_dec(1'b1, 0, 1'b0, 0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // ADD X1
      step();
      set_dec(1'b1, 1, 1'b1, 1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // reads X1 on ra
      #1;
      nvec++; if (fwd_a !== 2'd1) begin nerr++; $display("FAIL fwd_ex got=%0d exp=1", fwd_a); end
      nvec++; if (fwd_b !== 2'd0) begin nerr++; $display("FAIL fwd_unused_rb got=%0d exp=0", fwd_b); end
      nvec++; if (stall_fd !== 1'b0) begin nerr++; $display("FAIL fwd_no_stall got=%b exp=0", stall_fd); end
      step();
      #1;
      nvec++; if (fwd_a !== 2'd2) begin nerr++; $display("FAIL fwd_mem got=%0d exp=2", fwd_a); end
      step();
      #1;
      nvec++; if (fwd_a !== 2'd3) begin nerr++; $display("FAIL fwd_wb got=%0d exp=3", fwd_a); end
      nvec++; if (nb_fwd_a !== 2'd0) begin nerr++; $display("FAIL fwd_wb_nobypass got=%0d exp=0", nb_fwd_a); end
      step();
      #1;
      nvec++; if (fwd_a !== 2'd0) begin nerr++; $display("FAIL fwd_retired got=%0d exp=0", fwd_a); end
      // EX and MEM both write X3: the younger EX result wins.
      set_dec(1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      step();
      set_dec(1'b1, 0, 1'b0, 3, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      nvec++; if (fwd_b !== 2'd1) begin nerr++; $display("FAIL fwd_priority got=%0d exp=1", fwd_b); end
      drain();
      $display("test_forward done");
   endtask

   task automatic test_load_use();
      set_dec(1'b1, 0, 1'b0, 0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // LDUR X2
      step();
      set_dec(1'b1, 0, 1'b0, 2, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // reads X2 on rb
      #1;
      nvec++; if ({stall_fd, bubble_ex} !== 2'b11) begin nerr++; $display("FAIL ldu_stall got=%b exp=11", {stall_fd, bubble_ex}); end
      nvec++; if (flush_fd !== 1'b0) begin nerr++; $display("FAIL ldu_no_flush got=%b exp=0", flush_fd); end
      step();
      exp_stall++;
      #1;
      nvec++; if (ex_valid !== 1'b0) begin nerr++; $display("FAIL ldu_bubble got=%b exp=0", ex_valid); end
      nvec++; if (stall_fd !== 1'b0) begin nerr++; $display("FAIL ldu_one_cycle got=%b exp=0", stall_fd); end
      nvec++; if (fwd_b !== 2'd2) begin nerr++; $display("FAIL ldu_fwd_mem got=%0d exp=2", fwd_b); end
      nvec++; if (stall_cnt !== CW'(exp_stall)) begin nerr++; $display("FAIL ldu_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
      step();
      drain();
      $display("test_load_use done");
   endtask

   task automatic test_zero_reg();
      set_dec(1'b1, 0, 1'b0, 0, 1'b0, 31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // LDUR X31
      step();
      set_dec(1'b1, 31, 1'b1, 0, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      nvec++; if (fwd_a !== 2'd0) begin nerr++; $display("FAIL zero_fwd got=%0d exp=0", fwd_a); end
      nvec++; if (stall_fd !== 1'b0) begin nerr++; $display("FAIL zero_stall got=%b exp=0", stall_fd); end
      drain();
      $display("test_zero_reg done");
   endtask

   task automatic test_branch();
      set_dec(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      #1;
      nvec++; if (flush_fd !== 1'b1) begin nerr++; $display("FAIL br_flush got=%b exp=1", flush_fd); end
      step();
      exp_flush++;
      idle();
      #1;
      nvec++; if (flush_cnt !== CW'(exp_flush)) begin nerr++; $display("FAIL br_cnt got=%0d exp=%0d", flush_cnt, exp_flush); end
      nvec++; if (ex_valid !== 1'b0) begin nerr++; $display("FAIL br_ex_invalid got=%b exp=0", ex_valid); end
      nvec++; if (flush_fd !== 1'b0) begin nerr++; $display("FAIL br_one_cycle got=%b exp=0", flush_fd); end
      // Branch coinciding with a load-use hazard: stall first, flush next cycle.
      set_dec(1'b1, 0, 1'b0, 0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      set_dec(1'b1, 0, 1'b0, 2, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      #1;
      nvec++; if ({stall_fd, flush_fd} !== 2'b10) begin nerr++; $display("FAIL br_vs_stall got=%b exp=10", {stall_fd, flush_fd}); end
      step();
      exp_stall++;
      #1;
      nvec++; if ({stall_fd, flush_fd} !== 2'b01) begin nerr++; $display("FAIL br_retry got=%b exp=01", {stall_fd, flush_fd}); end
      step();
      exp_flush++;
      idle();
      #1;
      nvec++; if (flush_cnt !== CW'(exp_flush) || stall_cnt !== CW'(exp_stall)) begin
         nerr++; $display("FAIL br_cnts got=%0d/%0d exp=%0d/%0d", flush_cnt, stall_cnt, exp_flush, exp_stall);
      end
      drain();
      $display("test_branch done");
   endtask

   task automatic test_freeze();
      set_dec(1'b1, 0, 1'b0, 0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      idle();
      step();
      mem_ready = 1'b0;
      set_dec(1'b1, 0, 1'b0, 2, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int c = 0; c < 3; c++) begin
         #1;
         nvec++; if (freeze !== 1'b1) begin nerr++; $display("FAIL frz_on[%0d] got=%b exp=1", c, freeze); end
         nvec++; if ({ex_valid, mem_valid, wb_valid} !== 3'b010) begin nerr++; $display("FAIL frz_hold[%0d] got=%b exp=010", c, {ex_valid, mem_valid, wb_valid}); end
         nvec++; if ({stall_fd, bubble_ex, flush_fd} !== 3'b000) begin nerr++; $display("FAIL frz_ctrl[%0d] got=%b exp=000", c, {stall_fd, bubble_ex, flush_fd}); end
         nvec++; if (fwd_b !== 2'd2) begin nerr++; $display("FAIL frz_fwd[%0d] got=%0d exp=2", c, fwd_b); end
         nvec++; if (flush_cnt !== CW'(exp_flush) || stall_cnt !== CW'(exp_stall)) begin
            nerr++; $display("FAIL frz_cnt[%0d] got=%0d/%0d exp=%0d/%0d", c, flush_cnt, stall_cnt, exp_flush, exp_stall);
         end
         step();
      end
      mem_ready = 1'b1;
      idle();
      #1;
      nvec++; if (freeze !== 1'b0) begin nerr++; $display("FAIL frz_release got=%b exp=0", freeze); end
      step();
      #1;
      nvec++; if ({mem_valid, wb_valid} !== 2'b01) begin nerr++; $display("FAIL frz_resume got=%b exp=01", {mem_valid, wb_valid}); end
      drain();
      $display("test_freeze done");
   endtask

   task automatic test_flags();
      set_dec(1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); // SUBS
      step();
      set_dec(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); // B.LT
      #1;
      nvec++; if (fwd_flags !== 1'b1) begin nerr++; $display("FAIL flags_fwd got=%b exp=1", fwd_flags); end
      step();
      #1;
      nvec++; if (fwd_flags !== 1'b0) begin nerr++; $display("FAIL flags_nofw got=%b exp=0", fwd_flags); end
      drain();
      $display("test_flags done");
   endtask

   task automatic test_reset_mid_freeze();
      set_dec(1'b1, 0, 1'b0, 0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      idle();
      step();
      mem_ready = 1'b0;
      set_dec(1'b1, 0, 1'b0, 2, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      #1;
      nvec++; if (freeze !== 1'b1) begin nerr++; $display("FAIL rmf_pre got=%b exp=1", freeze); end
      reset = 1'b0;
      #1;
      nvec++; if ({freeze, stall_fd, bubble_ex, flush_fd} !== 4'd0) begin nerr++; $display("FAIL rmf_ctrl got=%b exp=0000", {freeze, stall_fd, bubble_ex, flush_fd}); end
      nvec++; if ({fwd_a, fwd_b} !== 4'd0) begin nerr++; $display("FAIL rmf_fwd got=%b exp=0000", {fwd_a, fwd_b}); end
      nvec++; if ({ex_valid, mem_valid, wb_valid} !== 3'd0) begin nerr++; $display("FAIL rmf_valid got=%b exp=000", {ex_valid, mem_valid, wb_valid}); end
      nvec++; if (stall_cnt !== 0 || flush_cnt !== 0) begin nerr++; $display("FAIL rmf_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
      idle();
      mem_ready = 1'b1;
      reset = 1'b1;
      exp_stall = 0;
      exp_flush = 0;
      step();
      $display("test_reset_mid_freeze done");
   endtask

   // A load that reads its own destination keeps re-creating the hazard, so
   // stalls occur on every odd cycle (the even cycles carry the bubble).
   task automatic test_back_to_back();
      int exp_now;
      set_dec(1'b1, 0, 1'b0, 2, 1'b1, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 37; k++) begin
         #1;
         nvec++; if (stall_fd !== ((k % 2) == 1)) begin nerr++; $display("FAIL b2b_stall[%0d] got=%b exp=%b", k, stall_fd, (k % 2) == 1); end
         step();
         exp_now = (k + 1) / 2;
         if (exp_now > 15) exp_now = 15;
         nvec++; if (stall_cnt !== CW'(exp_now)) begin nerr++; $display("FAIL b2b_cnt[%0d] got=%0d exp=%0d", k, stall_cnt, exp_now); end
      end
      nvec++; if (stall_cnt !== 4'hF) begin nerr++; $display("FAIL sat_final got=%0d exp=15", stall_cnt); end
      nvec++; if (flush_cnt !== 4'h0) begin nerr++; $display("FAIL sat_flush got=%0d exp=0", flush_cnt); end
      drain();
      $display("test_back_to_back done");
   endtask

   initial begin
      idle();
      reset = 1'b0;
      mem_ready = 1'b1;
      #2;
      test_reset();
      test_forward();
      test_load_use();
      test_zero_reg();
      test_branch();
      test_freeze();
      test_flags();
      test_reset_mid_freeze();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
